aes_dec_arbiter: RTL and testbench
==================================

AES_DEC_ARBITER -- requirements
Module: aes_dec_arbiter

Interface
REQ-001 SHALL have parameter: BLOCK_W, 128, width of cipher/plain blocks.
REQ-002 SHALL have clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst  in  1  reset; asynchronous and active-high.
REQ-004 SHALL have reqN_valid  in  1  requester N (N=0,1) has a block to decipher.
REQ-005 SHALL have reqN_keylen  in  1  requester N key length, 0=AES128, 1=AES256.
REQ-006 SHALL have reqN_block  in  BLOCK_W  requester N ciphertext.
REQ-007 SHALL have reqN_ready  out  1  one-cycle accept strobe to requester N.
REQ-008 SHALL have respN_valid  out  1  plaintext for requester N available.
REQ-009 SHALL have respN_block  out  BLOCK_W  plaintext to requester N.
REQ-010 SHALL have respN_ready  in  1  requester N consumes response.
REQ-011 SHALL have core_next  out  1  start pulse to shared decipher core.
REQ-012 SHALL have core_keylen  out  1  key length driven to core.
REQ-013 SHALL have core_block  out  BLOCK_W  ciphertext driven to core.
REQ-014 SHALL have core_new_block  in  BLOCK_W  core result.
REQ-015 SHALL have core_ready  in  1  core one-cycle done pulse.
REQ-016 SHALL have key_sel  out  1  granted requester index, selects that requester's round-key store.
REQ-017 SHALL have busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, START, WAIT, RESP.
REQ-019 IDLE: if any reqN_valid, grant one, assert its reqN_ready for that cycle, register reqN_block/reqN_keylen into core_block/core_keylen, set key_sel=N, go START; else stay.
REQ-020 Both valid in IDLE: grant requester not granted last (round-robin pointer); pointer reset value favours requester 0.
REQ-021 START: core_next=1 for exactly one cycle, go WAIT.
REQ-022 WAIT: hold core_block, core_keylen, key_sel stable; on core_ready capture core_new_block into respN_block, go RESP.
REQ-023 RESP: respN_valid=1 for granted N only; on respN_ready go IDLE and update pointer; hold otherwise, no other request accepted.
REQ-024 Arbiter overhead SHALL be exactly 3 cycles: accept, start, and result capture; core latency adds between START and core_ready.
REQ-025 core_next SHALL never assert outside START; reqN_ready never asserts outside IDLE; at most one reqN_ready per cycle.
REQ-026 reqN_valid dropped before acceptance SHALL be ignored without state change.
REQ-027 core_ready seen in IDLE, START or RESP SHALL be ignored.
REQ-028 respN_block SHALL hold its value until next capture for requester N.

Reset
REQ-029 rst asserted SHALL force IDLE immediately, mid-operation included; pending request and response dropped.
REQ-030 Reset values: all valid/ready/next/busy outputs 0, core_block 0, core_keylen 0, key_sel 0, respN_block 0, pointer favours requester 0.
REQ-031 Decipher core SHALL share the same reset net (inverted at top to its active-low input).

Configuration
REQ-032 Macro AES_DEC_ARB_FIXED_PRIO_EN defined: requester 0 always wins simultaneous requests, pointer removed.
REQ-033 Macro undefined: round-robin per REQ-020.

Verification
REQ-034 Single req0 with FIPS-197 AES128 ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, keylen=0 -> resp0_block 00112233445566778899aabbccddeeff, resp1_valid never high.
REQ-035 req0 and req1 valid same cycle, three transactions each -> grants 0,1,0,1,0,1; macro defined -> 0,0,0,1,1,1.
REQ-036 resp0_ready held low 20 cycles in RESP -> resp0_valid/resp0_block stable, req1_ready stays 0, core_next stays 0.
REQ-037 rst pulse two cycles after core_next -> next cycle busy=0, respN_valid=0; fresh request afterwards completes correctly.
REQ-038 Spurious core_ready in IDLE and RESP -> no state change, respN_block unchanged.

Source files
------------

// File: rtl/aes_dec_arbiter.sv
// Two-requester front end sharing one AES decipher core.
// Define AES_DEC_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties).
module aes_dec_arbiter #(
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0_valid,
  input  logic               req0_keylen,
  input  logic [BLOCK_W-1:0] req0_block,
  output logic               req0_ready,
  output logic               resp0_valid,
  output logic [BLOCK_W-1:0] resp0_block,
  input  logic               resp0_ready,

  input  logic               req1_valid,
  input  logic               req1_keylen,
  input  logic [BLOCK_W-1:0] req1_block,
  output logic               req1_ready,
  output logic               resp1_valid,
  output logic [BLOCK_W-1:0] resp1_block,
  input  logic               resp1_ready,

  output logic               core_next,
  output logic               core_keylen,
  output logic [BLOCK_W-1:0] core_block,
  input  logic [BLOCK_W-1:0] core_new_block,
  input  logic               core_ready,

  output logic               key_sel,
  output logic               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  typedef struct packed {
    logic               keylen;
    logic [BLOCK_W-1:0] block;
  } req_t;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       any_req;
  logic       pick;
  logic       accept;
  logic       capture;
  logic       resp_hs;
  req_t       req_sel;

`ifdef AES_DEC_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = ~req0_valid;
  end
`else
  // last_gnt resets to 1 so the first tie goes to requester 0
  logic last_gnt;

  always_comb begin
    if (req0_valid && req1_valid)
      pick = ~last_gnt;
    else
      pick = req1_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_gnt <= 1'b1;
    else if (resp_hs)
      last_gnt <= key_sel;
  end
`endif

  assign any_req = req0_valid | req1_valid;
  assign accept  = (state == IDLE) & any_req;
  assign capture = (state == WAIT) & core_ready;
  assign resp_hs = (state == RESP) &
                   (key_sel ? resp1_ready : resp0_ready);

  assign req0_ready  = accept & ~pick;
  assign req1_ready  = accept & pick;
  assign core_next   = (state == START);
  assign busy        = (state != IDLE);
  assign resp0_valid = (state == RESP) & ~key_sel;
  assign resp1_valid = (state == RESP) & key_sel;

  always_comb begin
    if (pick)
      req_sel = '{keylen: req1_keylen, block: req1_block};
    else
      req_sel = '{keylen: req0_keylen, block: req0_block};
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE):  if (any_req) state_nxt = START;
      (state == START): state_nxt = WAIT;
      (state == WAIT):  if (core_ready) state_nxt = RESP;
      (state == RESP):  if (resp_hs) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Core operands only move on accept, so they stay stable through WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_block  <= '0;
      core_keylen <= 1'b0;
      key_sel     <= 1'b0;
    end else if (accept) begin
      core_block  <= req_sel.block;
      core_keylen <= req_sel.keylen;
      key_sel     <= pick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      resp0_block <= '0;
    else if (capture && !key_sel)
      resp0_block <= core_new_block;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      resp1_block <= '0;
    else if (capture && key_sel)
      resp1_block <= core_new_block;
  end

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Bench for aes_dec_arbiter: transaction-level model, core emulated here.
// Honours AES_DEC_ARB_FIXED_PRIO_EN for the expected grant rule.
module tb_aes_dec_arbiter;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_keylen, req0_ready;
  logic [W-1:0] req0_block;
  logic         resp0_valid, resp0_ready;
  logic [W-1:0] resp0_block;
  logic         req1_valid, req1_keylen, req1_ready;
  logic [W-1:0] req1_block;
  logic         resp1_valid, resp1_ready;
  logic [W-1:0] resp1_block;
  logic         core_next, core_keylen, core_ready;
  logic [W-1:0] core_block, core_new_block;
  logic         key_sel, busy;

  always #5 clk = ~clk;

  aes_dec_arbiter #(.BLOCK_W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_keylen(req0_keylen),
    .req0_block(req0_block), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_block(resp0_block),
    .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_keylen(req1_keylen),
    .req1_block(req1_block), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_block(resp1_block),
    .resp1_ready(resp1_ready),
    .core_next(core_next), .core_keylen(core_keylen),
    .core_block(core_block), .core_new_block(core_new_block),
    .core_ready(core_ready),
    .key_sel(key_sel), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] blk;
    logic         kl;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   grants[$];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: one outstanding transaction at most
  bit           act;
  int           cyc, t_acc, t_cr, lat;
  bit           gnt_m, last_m;
  logic [W-1:0] blk_m, r0_m, r1_m;
  bit           kl_m;
  int           lat_lo = 1, lat_hi = 6;
  bit           rand_v, rand_r, spur, hold0;

  localparam logic [W-1:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [W-1:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in decipher: FIPS-197 vector, otherwise a keyed permutation
  function automatic logic [W-1:0] dec(logic [W-1:0] b, logic kl);
    if (b == FIPS_CT && !kl)
      return FIPS_PT;
    return {b[63:0], b[127:64]} ^
           (kl ? {4{32'h3c5a96e1}} : {4{32'h0f1e2d3c}});
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(int who, logic [W-1:0] b, logic kl);
    txn_t t;
    t.blk = b;
    t.kl  = kl;
    if (who == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic drive();
    if (q0.size() > 0 && (!rand_v || $urandom_range(0, 3) != 0)) begin
      req0_valid  = 1'b1;
      req0_block  = q0[0].blk;
      req0_keylen = q0[0].kl;
    end else begin
      req0_valid  = 1'b0;
      req0_block  = rnd();
      req0_keylen = 1'($urandom);
    end
    if (q1.size() > 0 && (!rand_v || $urandom_range(0, 3) != 0)) begin
      req1_valid  = 1'b1;
      req1_block  = q1[0].blk;
      req1_keylen = q1[0].kl;
    end else begin
      req1_valid  = 1'b0;
      req1_block  = rnd();
      req1_keylen = 1'($urandom);
    end
    resp0_ready = hold0 ? 1'b0 : (rand_r ? 1'($urandom) : 1'b1);
    resp1_ready = rand_r ? 1'($urandom) : 1'b1;
    if (act && t_cr < 0 && cyc == t_acc + 1 + lat) begin
      core_ready     = 1'b1;
      core_new_block = dec(blk_m, kl_m);
    end else if (spur && (!act || cyc == t_acc + 1 || t_cr >= 0)) begin
      core_ready     = 1'($urandom);
      core_new_block = rnd();
    end else begin
      core_ready     = 1'b0;
      core_new_block = rnd();
    end
  endtask

  task automatic tick();
    bit   e0, e1, eg, ev0, ev1;
    txn_t t;
    drive();
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!act && (req0_valid || req1_valid)) begin
`ifdef AES_DEC_ARB_FIXED_PRIO_EN
      eg = !req0_valid;
`else
      eg = (req0_valid && req1_valid) ? !last_m : req1_valid;
`endif
      e0 = !eg;
      e1 = eg;
    end
    ev0 = act && t_cr >= 0 && !gnt_m;
    ev1 = act && t_cr >= 0 && gnt_m;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("busy", busy, act);
    chk("core_next", core_next, act && cyc == t_acc + 1);
    chk("resp0_valid", resp0_valid, ev0);
    chk("resp1_valid", resp1_valid, ev1);
    chk("resp0_block", resp0_block, r0_m);
    chk("resp1_block", resp1_block, r1_m);
    if (act && cyc > t_acc) begin
      chk("key_sel", key_sel, gnt_m);
      chk("core_block", core_block, blk_m);
      chk("core_keylen", core_keylen, kl_m);
    end
    if (act && t_cr < 0 && cyc >= t_acc + 2 && core_ready) begin
      t_cr = cyc;
      if (gnt_m) r1_m = dec(blk_m, kl_m);
      else r0_m = dec(blk_m, kl_m);
    end
    if ((ev0 && resp0_ready) || (ev1 && resp1_ready)) begin
      act    = 1'b0;
      last_m = gnt_m;
    end
    if (e0 || e1) begin
      t     = e1 ? q1.pop_front() : q0.pop_front();
      act   = 1'b1;
      t_acc = cyc;
      t_cr  = -1;
      gnt_m = e1;
      blk_m = t.blk;
      kl_m  = t.kl;
      lat   = $urandom_range(lat_lo, lat_hi);
      grants.push_back(int'(e1));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((act || q0.size() > 0 || q1.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    core_ready  = 1'b0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_core_next", core_next, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_core_block", core_block, 0);
    chk("rst_core_keylen", core_keylen, 0);
    chk("rst_key_sel", key_sel, 0);
    chk("rst_resp0_block", resp0_block, 0);
    chk("rst_resp1_block", resp1_block, 0);
    act    = 1'b0;
    last_m = 1'b1;
    r0_m   = '0;
    r1_m   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    int exp_g[6];
    int n;
    req0_block     = '0;
    req1_block     = '0;
    req0_keylen    = 1'b0;
    req1_keylen    = 1'b0;
    core_new_block = '0;
    cyc            = 0;
    t_acc          = 0;
    t_cr           = -1;
    do_reset();

    // FIPS-197 single request from requester 0
    push(0, FIPS_CT, 1'b0);
    drain(50);
    chk("fips_plaintext", resp0_block, FIPS_PT);
    repeat (3) tick();

    // Simultaneous streams: grant order
    do_reset();
    grants.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, rnd(), 1'($urandom));
      push(1, rnd(), 1'($urandom));
    end
    drain(200);
`ifdef AES_DEC_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 1, 1, 1};
`else
    exp_g = '{0, 1, 0, 1, 0, 1};
`endif
    chk("grant_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk($sformatf("grant_%0d", i), grants[i], exp_g[i]);

    // Response back-pressure for 20 cycles with req1 waiting
    hold0 = 1'b1;
    push(0, rnd(), 1'b1);
    n = 0;
    while (!(act && t_cr >= 0) && n < 30) begin
      tick();
      n++;
    end
    chk("reach_resp", act && t_cr >= 0, 1);
    push(1, rnd(), 1'b0);
    repeat (20) tick();
    hold0 = 1'b0;
    drain(100);

    // Reset two cycles after the core start pulse
    lat_lo = 8;
    lat_hi = 8;
    push(0, rnd(), 1'b0);
    n = 0;
    while (!(act && cyc == t_acc + 3) && n < 30) begin
      tick();
      n++;
    end
    chk("reach_mid_wait", act && cyc == t_acc + 3, 1);
    do_reset();
    lat_lo = 1;
    lat_hi = 6;
    push(0, rnd(), 1'b1);
    drain(50);

    // Spurious core_ready outside WAIT
    spur = 1'b1;
    repeat (10) tick();
    hold0 = 1'b1;
    push(1, rnd(), 1'b0);
    push(0, rnd(), 1'b1);
    n = 0;
    while (!(act && t_cr >= 0 && !gnt_m) && n < 60) begin
      tick();
      n++;
    end
    repeat (8) tick();
    hold0 = 1'b0;
    drain(100);

    // Random traffic
    rand_v = 1'b1;
    rand_r = 1'b1;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) push(0, rnd(), 1'($urandom));
      repeat ($urandom_range(0, 3)) push(1, rnd(), 1'($urandom));
      drain(600);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
